// File: rtl/core_lsu_if.sv
// core_lsu_if: request, load-result and memory-port signals of the load/store unit.
// master = pipeline and memory side, slave = core_lsu.
interface core_lsu_if #(
  parameter int REG_W     = 8,
  parameter int CORE_ID_W = 4
);
  localparam int ADDR_W = CORE_ID_W + REG_W;

  logic              req_valid;
  logic [1:0]        req_op;
  logic [REG_W-1:0]  req_base;
  logic [REG_W-1:0]  req_offset;
  logic [REG_W-1:0]  req_wdata;
  logic              req_ready;
  logic              ld_valid;
  logic [REG_W-1:0]  ld_data;
  logic              idle;
  logic [1:0]        enable_M;
  logic [ADDR_W-1:0] addr_M;
  logic [REG_W-1:0]  wr_data_M;
  logic [REG_W-1:0]  rd_data_M;
  logic              ready_M;

  modport master (
    output req_valid, req_op, req_base, req_offset, req_wdata, rd_data_M, ready_M,
    input  req_ready, ld_valid, ld_data, idle, enable_M, addr_M, wr_data_M
  );

  modport slave (
    input  req_valid, req_op, req_base, req_offset, req_wdata, rd_data_M, ready_M,
    output req_ready, ld_valid, ld_data, idle, enable_M, addr_M, wr_data_M
  );
endinterface

// File: rtl/core_lsu.sv
// core_lsu: load/store unit between the M stage and the shared memory port.
// Stores are posted into a circular store buffer and drained in order; loads
// go to memory unless forwarded from the buffer.
// Optional feature: define CORE_LSU_FWD_EN to build store-to-load forwarding.
// Without it, loads wait until the buffer is empty and always go to memory.
module core_lsu #(
  parameter int REG_W     = 8,
  parameter int CORE_ID_W = 4,
  parameter int SB_DEPTH  = 4
) (
  input logic       clk,
  input logic       reset,
  core_lsu_if.slave bus
);
  localparam int ADDR_W = CORE_ID_W + REG_W;
  localparam int PTR_W  = $clog2(SB_DEPTH);

  localparam logic [1:0] OP_LD   = 2'b01;
  localparam logic [1:0] OP_ST   = 2'b10;
  localparam logic [1:0] EN_NONE = 2'b00;
  localparam logic [1:0] EN_RD   = 2'b01;
  localparam logic [1:0] EN_WR   = 2'b10;

  typedef enum logic [1:0] {IDLE, LD_MEM, ST_DRAIN} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [REG_W-1:0]  sb_data [SB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  logic [ADDR_W-1:0] req_addr;
  logic              sb_empty, sb_full, ld_ok;
  logic              ld_acc, st_push, sb_pop;
  logic              fwd_hit;
  logic [REG_W-1:0]  fwd_data;

  logic [1:0]        enable_d;
  logic [ADDR_W-1:0] addr_d;
  logic [REG_W-1:0]  wr_data_d;
  logic              ld_valid_d;
  logic [REG_W-1:0]  ld_data_d;

  assign req_addr = {bus.req_base[CORE_ID_W-1:0], bus.req_offset};
  assign sb_empty = (count == '0);
  assign sb_full  = (count == (PTR_W+1)'(SB_DEPTH));

`ifdef CORE_LSU_FWD_EN
  assign ld_ok = (state == IDLE);
`else
  assign ld_ok = (state == IDLE) && sb_empty;
`endif

  assign ld_acc   = bus.req_valid && (bus.req_op == OP_LD) && ld_ok;
  assign st_push  = bus.req_valid && (bus.req_op == OP_ST) && !sb_full;
  assign sb_pop   = (state == ST_DRAIN) && bus.ready_M;
  assign bus.idle = sb_empty && (state == IDLE);

  // Accept rules per opcode; unknown opcodes are always taken and dropped.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    bus.req_ready = 1'b1;
    unique case (bus.req_op)
      OP_LD:   bus.req_ready = ld_ok;
      OP_ST:   bus.req_ready = !sb_full;
      default: bus.req_ready = 1'b1;
    endcase
  end

`ifdef CORE_LSU_FWD_EN
  // Scan live entries oldest to youngest so the youngest matching store wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (sb_addr[idx] == req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[idx];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next state: a missing load in IDLE beats a pending drain.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (ld_acc && !fwd_hit) next_state = LD_MEM;
        else if (!ld_acc && !sb_empty) next_state = ST_DRAIN;
      end
      LD_MEM:   if (bus.ready_M) next_state = IDLE;
      ST_DRAIN: if (bus.ready_M) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Next values of the registered memory-port and load-result outputs.
  always_comb begin
    enable_d   = bus.enable_M;
    addr_d     = bus.addr_M;
    wr_data_d  = bus.wr_data_M;
    ld_valid_d = 1'b0;
    ld_data_d  = bus.ld_data;
    unique case (state)
      IDLE: begin
        if (ld_acc && fwd_hit) begin
          ld_valid_d = 1'b1;
          ld_data_d  = fwd_data;
        end else if (ld_acc) begin
          enable_d = EN_RD;
          addr_d   = req_addr;
        end else if (!sb_empty) begin
          enable_d  = EN_WR;
          addr_d    = sb_addr[rd_ptr];
          wr_data_d = sb_data[rd_ptr];
        end
      end
      LD_MEM: begin
        if (bus.ready_M) begin
          ld_valid_d = 1'b1;
          ld_data_d  = bus.rd_data_M;
          enable_d   = EN_NONE;
        end
      end
      ST_DRAIN: if (bus.ready_M) enable_d = EN_NONE;
      default: ;
    endcase
  end

  // Output registers and store-buffer pointers/occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.enable_M  <= EN_NONE;
      bus.addr_M    <= '0;
      bus.wr_data_M <= '0;
      bus.ld_valid  <= 1'b0;
      bus.ld_data   <= '0;
    end else begin
      if (st_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (sb_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({st_push, sb_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      bus.enable_M  <= enable_d;
      bus.addr_M    <= addr_d;
      bus.wr_data_M <= wr_data_d;
      bus.ld_valid  <= ld_valid_d;
      bus.ld_data   <= ld_data_d;
    end
  end

  // Store-buffer storage.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is not reset; only entries between rd_ptr and count are ever read.
    if (st_push) begin
      sb_addr[wr_ptr] <= req_addr;
      sb_data[wr_ptr] <= bus.req_wdata;
    end
  end
endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: table-driven vectors plus hand sequences for core_lsu.
// A program-order memory model predicts load results; a port-side memory
// model answers reads; queues hold expected writes and load results.
module tb_core_lsu;
  localparam int REG_W     = 8;
  localparam int CORE_ID_W = 4;
  localparam int SB_DEPTH  = 4;
  localparam int ADDR_W    = CORE_ID_W + REG_W;

  localparam logic [1:0] OP_LD = 2'b01;
  localparam logic [1:0] OP_ST = 2'b10;
  localparam logic [1:0] EN_RD = 2'b01;
  localparam logic [1:0] EN_WR = 2'b10;

`ifdef CORE_LSU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  core_lsu_if #(.REG_W(REG_W), .CORE_ID_W(CORE_ID_W)) bus ();

  core_lsu #(.REG_W(REG_W), .CORE_ID_W(CORE_ID_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } wr_t;

  typedef struct {
    logic [1:0]        op;
    logic [REG_W-1:0]  base;
    logic [REG_W-1:0]  off;
    logic [REG_W-1:0]  wdata;
    logic [ADDR_W-1:0] addr;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  logic [REG_W-1:0] phys_mem [logic [ADDR_W-1:0]];
  logic [REG_W-1:0] arch_mem [logic [ADDR_W-1:0]];
  wr_t              wr_q [$];
  logic [REG_W-1:0] ld_q [$];
  int               done_log [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_vec++;
    n_miss++;
    $display("FAIL %s: got 0x%0h, expected no such event", name, act);
  endtask

  function automatic logic [REG_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
  endfunction

  function automatic logic [REG_W-1:0] arch_rd(input logic [ADDR_W-1:0] a);
    return arch_mem.exists(a) ? arch_mem[a] : init_val(a);
  endfunction

  function automatic logic [REG_W-1:0] phys_rd(input logic [ADDR_W-1:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
  endfunction

  // Port monitor and memory model, on the falling edge.
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      if (bus.enable_M == EN_WR && bus.ready_M) begin
        if (wr_q.size() == 0) fail_now("unexpected_write", bus.addr_M);
        else begin
          e = wr_q.pop_front();
          check("wr_addr", bus.addr_M, e.addr);
          check("wr_data", bus.wr_data_M, e.data);
        end
        phys_mem[bus.addr_M] = bus.wr_data_M;
        done_log.push_back(2);
      end
      if (bus.enable_M == EN_RD && bus.ready_M) done_log.push_back(1);
      if (bus.ld_valid) begin
        if (ld_q.size() == 0) fail_now("unexpected_ld_valid", bus.ld_data);
        else check("ld_data", bus.ld_data, ld_q.pop_front());
      end
    end
    bus.rd_data_M = phys_rd(bus.addr_M);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted or the budget runs out.
  task automatic issue(input logic [1:0] op, input logic [REG_W-1:0] base, input logic [REG_W-1:0] off,
                       input logic [REG_W-1:0] wdata, input logic [ADDR_W-1:0] exp_addr,
                       input int budget, input bit track, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_base   = base;
    bus.req_offset = off;
    bus.req_wdata  = wdata;
    while (!ok && waited < budget) begin
      #1;
      if (bus.req_ready) begin
        ok = 1'b1;
        if (track && op == OP_ST) begin
          wr_q.push_back(wr_t'({exp_addr, wdata}));
          arch_mem[exp_addr] = wdata;
        end
        if (track && op == OP_LD) ld_q.push_back(arch_rd(exp_addr));
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && !bus.idle; i++) tick();
    check(name, bus.idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [11];
    bit   ok;
    int   waited;

    vecs[0]  = '{OP_ST, 8'h03, 8'h10, 8'hAA, 12'h310};
    vecs[1]  = '{OP_ST, 8'hF7, 8'h44, 8'h3C, 12'h744};
    vecs[2]  = '{OP_LD, 8'h0A, 8'h20, 8'h00, 12'hA20};
    vecs[3]  = '{2'b00, 8'h01, 8'h01, 8'h55, 12'h000};
    vecs[4]  = '{OP_ST, 8'h0F, 8'hFF, 8'hFF, 12'hFFF};
    vecs[5]  = '{OP_LD, 8'h00, 8'h00, 8'h00, 12'h000};
    vecs[6]  = '{2'b11, 8'h02, 8'h02, 8'h66, 12'h000};
    vecs[7]  = '{OP_LD, 8'h15, 8'hC3, 8'h00, 12'h5C3};
    vecs[8]  = '{OP_ST, 8'h10, 8'h00, 8'h01, 12'h000};
    vecs[9]  = '{OP_LD, 8'h27, 8'h44, 8'h00, 12'h744};
    vecs[10] = '{OP_LD, 8'h3F, 8'hFF, 8'h00, 12'hFFF};

    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_base   = '0;
    bus.req_offset = '0;
    bus.req_wdata  = '0;
    bus.ready_M    = 1'b0;
    bus.rd_data_M  = '0;
    phys_mem[12'h205] = 8'h5C;
    arch_mem[12'h205] = 8'h5C;

    // Reset state.
    reset = 1'b0;
    repeat (2) tick();
    check("rst_ld_valid", bus.ld_valid, 0);
    check("rst_ld_data", bus.ld_data, 0);
    check("rst_enable_M", bus.enable_M, 0);
    check("rst_addr_M", bus.addr_M, 0);
    check("rst_wr_data_M", bus.wr_data_M, 0);
    check("rst_idle", bus.idle, 1);
    reset = 1'b1;
    tick();

    // Table of single requests with the memory always ready.
    bus.ready_M = 1'b1;
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].base, vecs[i].off, vecs[i].wdata, vecs[i].addr, 60, 1'b1, ok, waited);
      check($sformatf("vec%0d_accept", i), ok, 1);
      if (vecs[i].op == 2'b00 || vecs[i].op == 2'b11)
        check($sformatf("vec%0d_bad_op_wait", i), waited, 0);
    end
    wait_idle("table_idle");

    // Single posted store drains one cycle after being buffered.
    issue(OP_ST, 8'h03, 8'h10, 8'hAA, 12'h310, 1, 1'b1, ok, waited);
    check("st_accept", ok, 1);
    check("st_idle_busy", bus.idle, 0);
    tick();
    check("st_enable_wr", bus.enable_M, EN_WR);
    check("st_addr_M", bus.addr_M, 12'h310);
    check("st_wr_data_M", bus.wr_data_M, 8'hAA);
    tick();
    check("st_enable_done", bus.enable_M, 0);
    check("st_idle_after", bus.idle, 1);

    // Fill the buffer while memory stalls, then drain in FIFO order.
    bus.ready_M = 1'b0;
    for (int k = 1; k <= SB_DEPTH; k++) begin
      issue(OP_ST, 8'(k), 8'(8'h40 + k), 8'(8'hD0 + k), {4'(k), 8'(8'h40 + k)}, 1, 1'b1, ok, waited);
      check($sformatf("full_push%0d", k), ok, 1);
    end
    bus.req_valid = 1'b1;
    bus.req_op    = OP_ST;
    #1;
    check("full_st_ready", bus.req_ready, 0);
    bus.req_op = OP_LD;
    #1;
    check("drain_ld_ready", bus.req_ready, 0);
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.ready_M   = 1'b1;
    wait_idle("full_drain_idle");
    check("full_wr_q_empty", wr_q.size(), 0);

    // Two stores to one address, then a load of it.
    wait_idle("fwd_start_idle");
    bus.ready_M = 1'b0;
    done_log.delete();
    issue(OP_ST, 8'h03, 8'h10, 8'h11, 12'h310, 1, 1'b1, ok, waited);
    check("fwd_st1_accept", ok, 1);
    issue(OP_ST, 8'h03, 8'h10, 8'h22, 12'h310, 1, 1'b1, ok, waited);
    check("fwd_st2_accept", ok, 1);
    fork
      issue(OP_LD, 8'h03, 8'h10, 8'h00, 12'h310, 60, 1'b1, ok, waited);
      begin
        repeat (3) tick();
        bus.ready_M = 1'b1;
      end
    join
    check("fwd_ld_accept", ok, 1);
    if (FWD) check("fwd_ld_valid_next", bus.ld_valid, 1);
    wait_idle("fwd_idle");
    check("fwd_mem_ops", done_log.size(), FWD ? 2 : 3);
    if (done_log.size() == 3) check("fwd_last_is_read", done_log[2], 1);

    // Load miss with the memory answering after three wait cycles.
    bus.ready_M = 1'b0;
    issue(OP_LD, 8'h02, 8'h05, 8'h00, 12'h205, 1, 1'b1, ok, waited);
    check("miss_accept", ok, 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("miss_enable%0d", k), bus.enable_M, EN_RD);
      check($sformatf("miss_addr%0d", k), bus.addr_M, 12'h205);
      bus.req_op = OP_LD;
      #1;
      check($sformatf("miss_ld_ready%0d", k), bus.req_ready, 0);
      bus.req_op = 2'b00;
      tick();
    end
    bus.ready_M = 1'b1;
    tick();
    bus.ready_M = 1'b0;
    check("miss_ld_valid", bus.ld_valid, 1);
    check("miss_ld_data", bus.ld_data, 8'h5C);
    check("miss_enable_done", bus.enable_M, 0);
    tick();
    check("miss_ld_pulse", bus.ld_valid, 0);
    check("miss_ld_data_hold", bus.ld_data, 8'h5C);

    // Load miss while the buffer holds one store.
    wait_idle("order_start_idle");
    bus.ready_M = 1'b1;
    done_log.delete();
    issue(OP_ST, 8'h06, 8'h06, 8'h66, 12'h606, 1, 1'b1, ok, waited);
    check("order_st_accept", ok, 1);
    issue(OP_LD, 8'h07, 8'h07, 8'h00, 12'h707, 60, 1'b1, ok, waited);
    check("order_ld_accept", ok, 1);
    if (FWD) check("order_read_first", bus.enable_M, EN_RD);
    wait_idle("order_idle");
    check("order_ops", done_log.size(), 2);
    if (done_log.size() == 2) begin
      check("order_first", done_log[0], FWD ? 1 : 2);
      check("order_second", done_log[1], FWD ? 2 : 1);
    end

    // Reset in the middle of a load miss abandons it.
    bus.ready_M = 1'b0;
    issue(OP_LD, 8'h02, 8'h05, 8'h00, 12'h205, 1, 1'b0, ok, waited);
    check("abort_accept", ok, 1);
    check("abort_enable_rd", bus.enable_M, EN_RD);
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("abort_enable", bus.enable_M, 0);
    check("abort_idle", bus.idle, 1);
    check("abort_ld_valid", bus.ld_valid, 0);
    bus.ready_M = 1'b1;
    repeat (3) tick();
    check("abort_no_pulse", bus.ld_valid, 0);

    check("end_wr_q_empty", wr_q.size(), 0);
    check("end_ld_q_empty", ld_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
